// File: rtl/sum_stats_collector.sv
// sum_stats_collector: collects blocks of N_SAMPLES adder sums and reports a
// saturating total, the minimum, the maximum and a saturation flag per block.
//
// Handshakes (both ports): a transfer happens on a rising clk edge where the
// producer's valid and the consumer's ready are both 1. in_ready and out_valid
// are pure decodes of the state register. A producer must not make valid
// depend on ready. Once out_valid is up it stays up, with the result frozen,
// until an edge sees out_ready=1. clear overrides both handshakes.
module sum_stats_collector #(
  parameter int SUM_W     = 5,
  parameter int N_SAMPLES = 8,
  parameter int ACC_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic [SUM_W-1:0] in_sum,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [ACC_W-1:0] out_total,
  output logic [SUM_W-1:0] out_min,
  output logic [SUM_W-1:0] out_max,
  output logic             out_sat,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             dbg_state
);

  // The count only has to reach N_SAMPLES-1 before it wraps back to zero.
  localparam int CNT_W = $clog2(N_SAMPLES + 1);
  // The addition is done one bit wider than the widest operand, so the carry
  // out of the accumulator is never lost before the clamp.
  localparam int WIDE_W = ((ACC_W > SUM_W) ? ACC_W : SUM_W) + 1;
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(N_SAMPLES - 1);
  localparam logic [WIDE_W-1:0] ACC_MAX  = {{(WIDE_W - ACC_W){1'b0}}, {ACC_W{1'b1}}};

  typedef enum logic {
    ST_COLLECT = 1'b0,
    ST_HOLD    = 1'b1
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  count;
  logic [WIDE_W-1:0] total_wide;
  logic              clamp;
  logic [ACC_W-1:0]  total_next;
  logic [SUM_W-1:0]  min_next;
  logic [SUM_W-1:0]  max_next;

  assign in_ready  = (state == ST_COLLECT);
  assign out_valid = (state == ST_HOLD);
  assign dbg_state = state;

  // Next block statistics, assuming the sample on in_sum is accepted this cycle.
  always_comb begin
    total_wide = WIDE_W'(out_total) + WIDE_W'(in_sum);
    clamp      = (total_wide > ACC_MAX);
    total_next = clamp ? {ACC_W{1'b1}} : total_wide[ACC_W-1:0];
    min_next   = (in_sum < out_min) ? in_sum : out_min;
    max_next   = (in_sum > out_max) ? in_sum : out_max;
  end

  // Collect/hold FSM. The result registers are the outputs themselves.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_COLLECT;
      count     <= '0;
      out_total <= '0;
      out_min   <= '1;
      out_max   <= '0;
      out_sat   <= 1'b0;
    end else if (clear) begin
      // An abort drops any sample seen this cycle and any unread result.
      state     <= ST_COLLECT;
      count     <= '0;
      out_total <= '0;
      out_min   <= '1;
      out_max   <= '0;
      out_sat   <= 1'b0;
    end else begin
      case (state)
        ST_COLLECT: begin
          if (in_valid) begin
            out_total <= total_next;
            out_sat   <= out_sat | clamp;
            out_min   <= min_next;
            out_max   <= max_next;
            if (count == LAST_CNT) begin
              count <= '0;
              state <= ST_HOLD;
            end else begin
              count <= count + 1'b1;
            end
          end
        end
        ST_HOLD: begin
          // The result stays frozen until it is taken. Input is not accepted
          // on the edge that releases it.
          if (out_ready) begin
            state     <= ST_COLLECT;
            out_total <= '0;
            out_min   <= '1;
            out_max   <= '0;
            out_sat   <= 1'b0;
          end
        end
        default: state <= ST_COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_sum_stats_collector.sv
// Bench for sum_stats_collector. It drives two instances from shared inputs:
// one with the default ACC_W=8 and one with ACC_W=7, which reaches saturation
// sooner. A block-level reference model checks every cycle.
module tb_sum_stats_collector;

  localparam int SUM_W = 5;
  localparam int N     = 8;
  localparam int MAX_A = 255;
  localparam int MAX_B = 127;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic             clear = 1'b0;
  logic             in_valid = 1'b0;
  logic             out_ready = 1'b0;
  logic [SUM_W-1:0] in_sum = '0;

  logic             a_in_ready, a_out_sat, a_out_valid, a_dbg_state;
  logic [7:0]       a_out_total;
  logic [SUM_W-1:0] a_out_min, a_out_max;
  logic             b_in_ready, b_out_sat, b_out_valid, b_dbg_state;
  logic [6:0]       b_out_total;
  logic [SUM_W-1:0] b_out_min, b_out_max;

  sum_stats_collector #(.SUM_W(SUM_W), .N_SAMPLES(N), .ACC_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_sum(in_sum), .in_valid(in_valid),
    .in_ready(a_in_ready), .out_total(a_out_total), .out_min(a_out_min),
    .out_max(a_out_max), .out_sat(a_out_sat), .out_valid(a_out_valid),
    .out_ready(out_ready), .dbg_state(a_dbg_state)
  );

  sum_stats_collector #(.SUM_W(SUM_W), .N_SAMPLES(N), .ACC_W(7)) dut7 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_sum(in_sum), .in_valid(in_valid),
    .in_ready(b_in_ready), .out_total(b_out_total), .out_min(b_out_min),
    .out_max(b_out_max), .out_sat(b_out_sat), .out_valid(b_out_valid),
    .out_ready(out_ready), .dbg_state(b_dbg_state)
  );

  // ---------------- scoreboard / model ----------------
  int n_checks = 0;
  int n_fail = 0;

  int         blk_q[$];   // samples accepted so far in the current block
  bit         m_hold = 1'b0;
  logic [7:0] exp_q[$];   // expected block totals, ACC_W=8 instance
  logic [6:0] exp7_q[$];  // expected block totals, ACC_W=7 instance

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int m_sum();
    int s = 0;
    foreach (blk_q[i]) s += blk_q[i];
    return s;
  endfunction

  function automatic int m_total(input int max_v);
    int s = m_sum();
    return (s > max_v) ? max_v : s;
  endfunction

  function automatic int m_min();
    int m = (1 << SUM_W) - 1;
    foreach (blk_q[i]) if (blk_q[i] < m) m = blk_q[i];
    return m;
  endfunction

  function automatic int m_max();
    int m = 0;
    foreach (blk_q[i]) if (blk_q[i] > m) m = blk_q[i];
    return m;
  endfunction

  task automatic model_reset();
    blk_q.delete();
    m_hold = 1'b0;
    exp_q.delete();
    exp7_q.delete();
  endtask

  task automatic compare_all();
    check("a_in_ready", a_in_ready, !m_hold);
    check("a_out_valid", a_out_valid, m_hold);
    check("a_dbg_state", a_dbg_state, m_hold);
    check("a_total", a_out_total, m_total(MAX_A));
    check("a_min", a_out_min, m_min());
    check("a_max", a_out_max, m_max());
    check("a_sat", a_out_sat, m_sum() > MAX_A);
    check("b_out_valid", b_out_valid, m_hold);
    check("b_total", b_out_total, m_total(MAX_B));
    check("b_min", b_out_min, m_min());
    check("b_max", b_out_max, m_max());
    check("b_sat", b_out_sat, m_sum() > MAX_B);
  endtask

  // ---------------- driver ----------------
  // Drive the inputs for one cycle, clock the edge, then update the model and compare.
  task automatic step(input bit c, input bit v, input logic [SUM_W-1:0] s, input bit r);
    clear = c; in_valid = v; in_sum = s; out_ready = r;
    if (m_hold && r && !c) begin
      if (exp_q.size() > 0) begin
        check("sb_total_a", a_out_total, exp_q.pop_front());
        check("sb_total_b", b_out_total, exp7_q.pop_front());
      end else begin
        check("sb_empty", 1, 0);
      end
    end
    @(posedge clk); #1;
    if (c) begin
      model_reset();
    end else if (!m_hold) begin
      if (v) begin
        blk_q.push_back(int'(s));
        if (blk_q.size() == N) begin
          m_hold = 1'b1;
          exp_q.push_back(8'(m_total(MAX_A)));
          exp7_q.push_back(7'(m_total(MAX_B)));
        end
      end
    end else if (r) begin
      blk_q.delete();
      m_hold = 1'b0;
    end
    compare_all();
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_total"}, a_out_total, 0);
    check({tag, "_min"}, a_out_min, 31);
    check({tag, "_max"}, a_out_max, 0);
    check({tag, "_sat"}, a_out_sat, 0);
    check({tag, "_valid"}, a_out_valid, 0);
    check({tag, "_ready"}, a_in_ready, 1);
    check({tag, "_b_total"}, b_out_total, 0);
    check({tag, "_b_valid"}, b_out_valid, 0);
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    bit         clr;
    bit         vld;
    logic [4:0] sum;
    bit         rdy;
    bit         e_ir;
    bit         e_ov;
    logic [7:0] e_tot;
    logic [4:0] e_min;
    logic [4:0] e_max;
    bit         e_sat;
  } vec_t;

  vec_t vecs[10];

  initial begin
    vecs[0] = '{1'b0, 1'b1, 5'd3, 1'b0, 1'b1, 1'b0, 8'd3,  5'd3,  5'd3, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 5'd3, 1'b0, 1'b1, 1'b0, 8'd6,  5'd3,  5'd3, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 5'd3, 1'b0, 1'b1, 1'b0, 8'd9,  5'd3,  5'd3, 1'b0};
    vecs[3] = '{1'b0, 1'b1, 5'd3, 1'b0, 1'b1, 1'b0, 8'd12, 5'd3,  5'd3, 1'b0};
    vecs[4] = '{1'b0, 1'b1, 5'd3, 1'b0, 1'b1, 1'b0, 8'd15, 5'd3,  5'd3, 1'b0};
    vecs[5] = '{1'b0, 1'b1, 5'd3, 1'b0, 1'b1, 1'b0, 8'd18, 5'd3,  5'd3, 1'b0};
    vecs[6] = '{1'b0, 1'b1, 5'd3, 1'b0, 1'b1, 1'b0, 8'd21, 5'd3,  5'd3, 1'b0};
    vecs[7] = '{1'b0, 1'b1, 5'd3, 1'b0, 1'b0, 1'b1, 8'd24, 5'd3,  5'd3, 1'b0};
    vecs[8] = '{1'b0, 1'b1, 5'd4, 1'b0, 1'b0, 1'b1, 8'd24, 5'd3,  5'd3, 1'b0};
    vecs[9] = '{1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 8'd0,  5'd31, 5'd0, 1'b0};

    // Reset
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("reset");
    rst_n = 1'b1;

    // Table: 8 samples of 3, one held cycle, then release.
    for (int i = 0; i < 10; i++) begin
      step(vecs[i].clr, vecs[i].vld, vecs[i].sum, vecs[i].rdy);
      check($sformatf("vec%0d_in_ready", i), a_in_ready, vecs[i].e_ir);
      check($sformatf("vec%0d_out_valid", i), a_out_valid, vecs[i].e_ov);
      check($sformatf("vec%0d_total", i), a_out_total, vecs[i].e_tot);
      check($sformatf("vec%0d_min", i), a_out_min, vecs[i].e_min);
      check($sformatf("vec%0d_max", i), a_out_max, vecs[i].e_max);
      check($sformatf("vec%0d_sat", i), a_out_sat, vecs[i].e_sat);
    end

    // Samples separated by two idle cycles each.
    begin
      logic [4:0] gap_s[8];
      gap_s = '{5'd1, 5'd31, 5'd0, 5'd7, 5'd5, 5'd5, 5'd2, 5'd9};
      for (int i = 0; i < 8; i++) begin
        step(1'b0, 1'b1, gap_s[i], 1'b0);
        if (i == 6) check("gap_no_early_valid", a_out_valid, 0);
        if (i == 7) begin
          check("gap_valid", a_out_valid, 1);
          check("gap_total", a_out_total, 60);
          check("gap_min", a_out_min, 0);
          check("gap_max", a_out_max, 31);
        end
        step(1'b0, 1'b0, 5'd0, 1'b0);
        step(1'b0, 1'b0, 5'd0, 1'b0);
      end
      step(1'b0, 1'b0, 5'd0, 1'b1);
    end

    // Saturation: 8 x 31 = 248 fits in 8 bits but clamps to 127 in 7 bits.
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 5'd31, 1'b0);
    check("sat_a_total", a_out_total, 248);
    check("sat_a_flag", a_out_sat, 0);
    check("sat_b_total", b_out_total, 127);
    check("sat_b_flag", b_out_sat, 1);
    check("sat_b_valid", b_out_valid, 1);

    // Backpressure while in_valid stays high.
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b1, 5'd4, 1'b0);
      check("bp_total_stable", a_out_total, 248);
      check("bp_in_ready", a_in_ready, 0);
    end
    step(1'b0, 1'b0, 5'd0, 1'b1);
    check("bp_release_ready", a_in_ready, 1);
    check("bp_release_total", a_out_total, 0);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 5'd4, 1'b0);
    check("bp_next_total", a_out_total, 32);
    step(1'b0, 1'b0, 5'd0, 1'b1);

    // clear part-way through a block, with a sample presented in the same cycle.
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 5'd6, 1'b0);
    step(1'b1, 1'b1, 5'd6, 1'b0);
    check("clr_total", a_out_total, 0);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 5'd2, 1'b0);
    check("clr_blk_total", a_out_total, 16);
    check("clr_blk_min", a_out_min, 2);
    check("clr_blk_max", a_out_max, 2);
    step(1'b1, 1'b0, 5'd0, 1'b0);
    check("clr_hold_valid", a_out_valid, 0);
    check("clr_hold_total", a_out_total, 0);

    // Asynchronous reset in the middle of a cycle, after 3 samples.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 5'd1, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    check_reset_values("async_rst");
    model_reset();
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 5'd1, 1'b0);
    check("post_rst_total", a_out_total, 8);
    step(1'b0, 1'b0, 5'd0, 1'b1);

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 40) == 0, $urandom_range(0, 3) != 0,
           5'($urandom_range(0, 31)), $urandom_range(0, 2) != 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Safety net so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sum_stats_collector.md
Name: sum_stats_collector

Overview:
- Downstream consumer of the 4-bit adder's 5-bit sum output.
- Accepts a stream of sums over a valid/ready handshake and accumulates a block of N_SAMPLES of them.
- Per block, produces a running total, a minimum, a maximum and a saturation flag.
- Presents the block result on a valid/ready output port and holds it until a downstream stage takes it.

Parameters:
- SUM_W, 5, width of incoming sum (adder output width).
- N_SAMPLES, 8, sums per block; legal range 2..255.
- ACC_W, 8, total accumulator width; saturates at 2^ACC_W-1.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- clear  in  1  synchronous block abort/restart.
- in_sum  in  SUM_W  sum from adder.
- in_valid  in  1  in_sum valid this cycle.
- in_ready  out  1  collector can accept in_sum.
- out_total  out  ACC_W  block total, saturating.
- out_min  out  SUM_W  smallest sum in block.
- out_max  out  SUM_W  largest sum in block.
- out_sat  out  1  total saturated during block.
- out_valid  out  1  block result valid.
- out_ready  in  1  downstream accepts result.

Behaviour:
- Reset (rst_n=0, async, any state):
  - state=COLLECT, in_ready=1, out_valid=0.
  - out_total=0, out_min=all ones (2^SUM_W-1), out_max=0, out_sat=0.
  - Internal sample count=0.
- FSM, two states:
  - COLLECT:
    - in_ready=1, out_valid=0.
    - Accept occurs on a rising edge where in_valid=1.
    - On accept: total+=in_sum, computed one bit wider, then clamped to 2^ACC_W-1; out_sat sets and stays set if the clamp engages.
    - On accept: min=min(min,in_sum), max=max(max,in_sum), count+=1.
    - When the accepted sample is sample N_SAMPLES: go to HOLD on that same edge; count returns to 0.
  - HOLD:
    - in_ready=0, out_valid=1.
    - Outputs are frozen and include the last sample.
    - in_sum is ignored.
    - Edge with out_ready=1: go to COLLECT; total=0, min=all ones, max=0, sat=0.
    - in_ready=1 from the next cycle; no same-cycle input acceptance.
- Latency: out_valid rises on the edge that accepts the final sample, i.e. visible the cycle after that handshake.
- out_ready is sampled only in HOLD; asserting it early has no effect.
- Stall: in_valid=0 in COLLECT leaves all state unchanged; gaps between samples are allowed.
- clear (synchronous, any state, priority over handshakes):
  - Next state COLLECT with reset values.
  - A sample presented in the same cycle is dropped, not counted.
  - An unconsumed HOLD result is discarded.
- Reset mid-block: partial accumulation is lost; no out_valid is produced for that block.
- Arithmetic: all values unsigned; min/max compare uses full SUM_W bits.
- Outputs are registered; no combinational path from inputs to outputs except none. in_ready and out_valid are decodes of the state register only.

Test Plan:
- Reset, then 8 consecutive samples of 3 (in_valid held 1) -> in_ready=1 throughout.
  - Edge after the 8th accept: out_valid=1, out_total=24, out_min=3, out_max=3, out_sat=0.
  - in_ready=0 in the same cycle.
- Samples 1,31,0,7,5,5,2,9 with in_valid gaps of 2 cycles between each -> out_total=60, out_min=0, out_max=31.
  - out_valid rises only after the 8th accept.
- Saturation with ACC_W=7 override: 8 samples of 31 -> total clamps at 127, out_sat=1, out_valid=1.
- Backpressure: hold out_ready=0 for 10 cycles in HOLD while driving in_valid=1, in_sum=4 -> outputs stable, no sample counted.
  - Then out_ready=1 for 1 cycle -> next cycle in_ready=1, out_total=0.
  - Next block of 8×4 gives total=32.
- clear asserted after 5 samples (with in_valid=1 that cycle) -> 8 further samples of 2 give out_total=16, min=max=2.
  - clear during HOLD drops the result, out_valid=0 next cycle.
- rst_n pulsed low asynchronously, mid-cycle, after 3 samples -> outputs immediately at reset values.
  - The following block of 8 samples of 1 yields out_total=8.
